fas_serial_ctrl: RTL and testbench
==================================

// Module: fas_serial_ctrl
// PURPOSE
//  Bit-serial add/subtract sequencer built around a single fas (full adder/subtractor) cell.
//  Accepts W-bit operands with a valid/ready handshake and feeds the fas one bit per cycle, LSB first.
//  Shifts the W-bit sum in and returns sum, carry-out and signed overflow on a valid/ready result port.
//  Sits between the ALU command front-end and the shared fas datapath cell.
// PARAMETERS
//  W   8   operand/result width in bits; legal range W >= 2
// PORTS
//  clk         in   1   clock, all state updates on rising edge
//  rst         in   1   reset, asynchronous, active-high
//  start_valid in   1   command valid
//  start_ready out  1   command accept; high only in IDLE
//  op_sub      in   1   0 = A+B, 1 = A-B; sampled on accept
//  op_a        in   W   operand A; sampled on accept
//  op_b        in   W   operand B; sampled on accept
//  busy        out  1   high in RUN and DONE
//  res_valid   out  1   result valid; high only in DONE
//  res_ready   in   1   result accept
//  res_s       out  W   sum/difference
//  res_cout    out  1   carry out of MSB (for subtract: 1 = no borrow)
//  res_ovf     out  1   two's-complement signed overflow
// BEHAVIOUR
//  - Reset (async, any state incl. mid-RUN): state=IDLE, all shift regs/counter/carry=0,
//    start_ready=1, busy=0, res_valid=0, res_s=0, res_cout=0, res_ovf=0. Partial work discarded.
//  - One fas instance; a_ns tied to 0 (add mode). Subtract done as A + ~B + 1.
//  - FSM IDLE -> RUN -> DONE -> IDLE:
//    IDLE: start_ready=1. On start_valid: a_sh<=op_a, b_sh<=op_sub ? ~op_b : op_b,
//      carry<=op_sub, cnt<=0, go RUN. No accept -> stay.
//    RUN: fas.a=a_sh[0], fas.b=b_sh[0], fas.cin=carry. Each cycle: s_sh<={fas.s, s_sh[W-1:1]},
//      a_sh/b_sh shift right 1, carry<=fas.cout, cnt<=cnt+1. Cycle with cnt==W-1 (MSB):
//      also latch cin_msb<=carry (carry into MSB), go DONE. start_valid ignored.
//    DONE: res_valid=1; res_s=s_sh, res_cout=carry, res_ovf=cin_msb ^ carry. Outputs held
//      stable until res_ready; on res_valid&&res_ready go IDLE.
//  - Latency: accept edge + W RUN edges -> res_valid high W+1 edges after the accept edge.
//    Minimum command-to-command spacing W+2 cycles (no bypass DONE->RUN).
//  - start_ready is 0 in DONE even if res_ready=1 that cycle; new command accepted next cycle in IDLE.
//  - res_ready while res_valid=0: no effect. Operand changes after accept: no effect.
//  - Arithmetic is modulo 2^W; cnt width $clog2(W), no wrap beyond W-1.
//  - Outside DONE, res_s/res_cout/res_ovf are 0 (registered, reset to 0).
// TESTING (W=8)
//  - Add 0x05+0x03, res_ready=1 -> res_valid 9 cycles after accept, res_s=0x08, cout=0, ovf=0.
//  - Add 0x7F+0x01 -> res_s=0x80, cout=0, ovf=1; add 0xFF+0x01 -> res_s=0x00, cout=1, ovf=0.
//  - Sub 0x03-0x05 -> res_s=0xFE, cout=0, ovf=0; sub 0x80-0x01 -> res_s=0x7F, cout=1, ovf=1.
//  - Backpressure: res_ready=0 for 5 cycles in DONE -> outputs stable, start_ready=0, busy=1;
//    res_ready=1 -> IDLE next edge; start_valid held high -> accepted the following cycle.
//  - start_valid pulsed with new operands during RUN -> ignored; first result unchanged.
//  - rst asserted 4 cycles into RUN -> immediately res_valid=0, busy=0, start_ready=1, res_s=0;
//    next command after release completes correctly.

Source files
------------

// File: rtl/fas_serial_ctrl.sv
// Bit-serial add/subtract sequencer: streams W-bit operands LSB first through one fas cell
// and returns sum, carry-out and signed overflow over a valid/ready result port.

module fas (
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic a_ns,
  output logic s,
  output logic cout
);
  logic a_eff;

  // a_ns inverts A, which turns the cell into a B - A stage; this sequencer ties it low
  assign a_eff = a ^ a_ns;
  assign s     = a_eff ^ b ^ cin;
  assign cout  = (a_eff & b) | (cin & (a_eff ^ b));
endmodule

module fas_serial_ctrl #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic         op_sub,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic         busy,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_s,
  output logic         res_cout,
  output logic         res_ovf
);
  localparam int unsigned CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nx;
  logic          accept_c, last_c, pop_c;
  logic [W-1:0]  a_sh, b_sh, s_sh;
  logic [CW-1:0] cnt;
  logic          carry;
  logic          fas_s, fas_cout;

  fas u_fas (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .a_ns (1'b0),
    .s    (fas_s),
    .cout (fas_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept_c = 1'b0;
    last_c   = 1'b0;
    pop_c    = 1'b0;
    case (state)
      IDLE: if (start_valid) begin
        accept_c = 1'b1;
        state_nx = RUN;
      end
      RUN: if (cnt == CW'(W - 1)) begin
        last_c   = 1'b1;
        state_nx = DONE;
      end
      DONE: if (res_ready) begin
        pop_c    = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Serial datapath; subtract is A + ~B + 1 with the +1 entering as the initial carry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      cnt   <= '0;
      carry <= 1'b0;
    end else if (accept_c) begin
      a_sh  <= op_a;
      b_sh  <= op_sub ? ~op_b : op_b;
      carry <= op_sub;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= {1'b0, a_sh[W-1:1]};
      b_sh  <= {1'b0, b_sh[W-1:1]};
      s_sh  <= {fas_s, s_sh[W-1:1]};
      carry <= fas_cout;
      if (!last_c) cnt <= cnt + CW'(1);
    end
  end

  // Registered handshake and result; carry entering the MSB is the carry register on the last RUN cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_ready <= 1'b1;
      busy        <= 1'b0;
      res_valid   <= 1'b0;
      res_s       <= '0;
      res_cout    <= 1'b0;
      res_ovf     <= 1'b0;
    end else begin
      start_ready <= (state_nx == IDLE);
      busy        <= (state_nx != IDLE);
      res_valid   <= (state_nx == DONE);
      if (last_c) begin
        res_s    <= {fas_s, s_sh[W-1:1]};
        res_cout <= fas_cout;
        res_ovf  <= carry ^ fas_cout;
      end else if (pop_c) begin
        res_s    <= '0;
        res_cout <= 1'b0;
        res_ovf  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fas_serial_ctrl.sv
// Self-checking bench for fas_serial_ctrl: directed vector table, multi-cycle corner
// sequences and randomized commands against an integer-arithmetic reference model.

module tb_fas_serial_ctrl;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_valid, start_ready, op_sub;
  logic [W-1:0] op_a, op_b;
  logic         busy, res_valid, res_ready;
  logic [W-1:0] res_s;
  logic         res_cout, res_ovf;

  int checks   = 0;
  int failures = 0;

  fas_serial_ctrl #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_sub      (op_sub),
    .op_a        (op_a),
    .op_b        (op_b),
    .busy        (busy),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_s       (res_s),
    .res_cout    (res_cout),
    .res_ovf     (res_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain signed/unsigned integer arithmetic on the operand values
  function automatic void model(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] s, output logic c, output logic o);
    int ia, ib, sa, sb, r, sr;
    ia = int'(a);
    ib = int'(b);
    sa = a[W-1] ? ia - (1 << W) : ia;
    sb = b[W-1] ? ib - (1 << W) : ib;
    if (sub) begin
      r  = ia - ib;
      c  = (ia >= ib);
      sr = sa - sb;
    end else begin
      r  = ia + ib;
      c  = (r >= (1 << W));
      sr = sa + sb;
    end
    s = W'(r);
    o = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
  endfunction

  // Called at a negedge; returns at the negedge just after the accept edge
  task automatic send(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = 0;
    while (!start_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!start_ready) check("send_ready_timeout", 32'(start_ready), 32'd1);
    start_valid = 1'b1;
    op_sub      = sub;
    op_a        = a;
    op_b        = b;
    @(negedge clk);
    start_valid = 1'b0;
    op_sub      = 1'($urandom);
    op_a        = W'($urandom);
    op_b        = W'($urandom);
  endtask

  // Edge count includes the accept edge
  task automatic wait_result(input int start_edges, output int edges);
    edges = start_edges;
    while (!res_valid && edges < 4 * W) begin
      @(negedge clk);
      edges++;
    end
    check("res_valid_seen", 32'(res_valid), 32'd1);
  endtask

  vec_t vecs[7];
  int   e;
  logic [W-1:0] ms;
  logic         mc, mo;

  initial begin
    vecs[0] = '{sub: 1'b0, a: 8'h05, b: 8'h03, s: 8'h08, c: 1'b0, o: 1'b0};
    vecs[1] = '{sub: 1'b0, a: 8'h7F, b: 8'h01, s: 8'h80, c: 1'b0, o: 1'b1};
    vecs[2] = '{sub: 1'b0, a: 8'hFF, b: 8'h01, s: 8'h00, c: 1'b1, o: 1'b0};
    vecs[3] = '{sub: 1'b1, a: 8'h03, b: 8'h05, s: 8'hFE, c: 1'b0, o: 1'b0};
    vecs[4] = '{sub: 1'b1, a: 8'h80, b: 8'h01, s: 8'h7F, c: 1'b1, o: 1'b1};
    vecs[5] = '{sub: 1'b1, a: 8'h00, b: 8'h00, s: 8'h00, c: 1'b1, o: 1'b0};
    vecs[6] = '{sub: 1'b0, a: 8'hFF, b: 8'hFF, s: 8'hFE, c: 1'b1, o: 1'b0};

    rst = 1'b1; start_valid = 1'b0; op_sub = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_start_ready", 32'(start_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_s", 32'(res_s), 32'd0);
    check("rst_res_cout", 32'(res_cout), 32'd0);
    check("rst_res_ovf", 32'(res_ovf), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed table with res_ready held high
    res_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].sub, vecs[i].a, vecs[i].b);
      check("vec_run_busy", 32'(busy), 32'd1);
      wait_result(1, e);
      check("vec_latency", 32'(e), 32'(W + 1));
      check("vec_s", 32'(res_s), 32'(vecs[i].s));
      check("vec_cout", 32'(res_cout), 32'(vecs[i].c));
      check("vec_ovf", 32'(res_ovf), 32'(vecs[i].o));
      check("vec_done_ready", 32'(start_ready), 32'd0);
      @(negedge clk);
      check("vec_pop_valid", 32'(res_valid), 32'd0);
      check("vec_pop_ready", 32'(start_ready), 32'd1);
      check("vec_pop_s", 32'(res_s), 32'd0);
    end

    // Backpressure in DONE with a new command waiting
    res_ready = 1'b0;
    send(1'b0, 8'h12, 8'h34);
    wait_result(1, e);
    start_valid = 1'b1; op_sub = 1'b1; op_a = 8'h40; op_b = 8'h02;
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", 32'(res_valid), 32'd1);
      check("bp_s", 32'(res_s), 32'h46);
      check("bp_start_ready", 32'(start_ready), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
    end
    res_ready = 1'b1;
    @(negedge clk);
    check("bp_idle_ready", 32'(start_ready), 32'd1);
    check("bp_idle_valid", 32'(res_valid), 32'd0);
    @(negedge clk);
    start_valid = 1'b0;
    check("bp_next_busy", 32'(busy), 32'd1);
    check("bp_next_ready", 32'(start_ready), 32'd0);
    wait_result(1, e);
    check("bp_next_latency", 32'(e), 32'(W + 1));
    check("bp_next_s", 32'(res_s), 32'h3E);
    check("bp_next_cout", 32'(res_cout), 32'd1);
    check("bp_next_ovf", 32'(res_ovf), 32'd0);
    @(negedge clk);

    // start_valid pulsed mid-RUN must be ignored
    send(1'b0, 8'h21, 8'h10);
    repeat (2) @(negedge clk);
    start_valid = 1'b1; op_sub = 1'b1; op_a = 8'hFF; op_b = 8'hFF;
    @(negedge clk);
    start_valid = 1'b0;
    wait_result(4, e);
    check("ign_latency", 32'(e), 32'(W + 1));
    check("ign_s", 32'(res_s), 32'h31);
    check("ign_cout", 32'(res_cout), 32'd0);
    @(negedge clk);

    // Asynchronous reset four cycles into RUN
    send(1'b0, 8'h55, 8'h22);
    repeat (3) @(negedge clk);
    check("mid_run_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(res_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_ready", 32'(start_ready), 32'd1);
    check("arst_s", 32'(res_s), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(1'b1, 8'h10, 8'h20);
    wait_result(1, e);
    check("post_rst_latency", 32'(e), 32'(W + 1));
    check("post_rst_s", 32'(res_s), 32'hF0);
    check("post_rst_cout", 32'(res_cout), 32'd0);
    check("post_rst_ovf", 32'(res_ovf), 32'd0);
    @(negedge clk);

    // Randomized commands with random result backpressure
    for (int i = 0; i < 300; i++) begin
      logic         sub;
      logic [W-1:0] a, b, held;
      int           rr;
      logic [W-1:0] corner[4];
      corner[0] = 8'h00; corner[1] = 8'h7F; corner[2] = 8'h80; corner[3] = 8'hFF;
      sub = 1'($urandom);
      a   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
      b   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
      rr  = int'($urandom_range(0, 3));
      res_ready = (rr == 0);
      model(sub, a, b, ms, mc, mo);
      send(sub, a, b);
      wait_result(1, e);
      check("rnd_latency", 32'(e), 32'(W + 1));
      check("rnd_s", 32'(res_s), 32'(ms));
      check("rnd_cout", 32'(res_cout), 32'(mc));
      check("rnd_ovf", 32'(res_ovf), 32'(mo));
      held = res_s;
      repeat (rr) @(negedge clk);
      if (rr > 0) begin
        check("rnd_hold_valid", 32'(res_valid), 32'd1);
        check("rnd_hold_s", 32'(res_s), 32'(held));
      end
      res_ready = 1'b1;
      @(negedge clk);
      check("rnd_pop_valid", 32'(res_valid), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
